// File: rtl/mult32_result_queue.sv
// Result queue for the 32x32 pipelined multiplier.
// Captures each product beat {result_h, result_l, usr} into an in-order FIFO,
// presents the head entry over a valid/ready handshake and raises io_stop
// early enough that the multiplier's in-flight beats still fit.
//
// Handshake: the head entry transfers on a rising edge where io_out_valid and
// io_out_ready are both high. io_out_valid never depends on io_out_ready, and
// the head data holds stable while io_out_valid && !io_out_ready.
module mult32_result_queue #(
    parameter int DEPTH = 4,
    parameter int SKID  = 1,
    parameter int USR_W = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  io_in_result_l,
    input  logic [31:0]                  io_in_result_h,
    input  logic [USR_W-1:0]             io_in_usr,
    input  logic                         io_in_en,
    output logic                         io_stop,
    output logic [63:0]                  io_out_data,
    output logic [USR_W-1:0]             io_out_usr,
    output logic                         io_out_valid,
    input  logic                         io_out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   io_count,
    output logic                         io_overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STOP_CNT = CNT_W'(DEPTH - SKID);

    // Entry storage is deliberately not reset; empty entries are masked on read.
    logic [63:0]      r_data_mem [DEPTH];
    logic [USR_W-1:0] r_usr_mem  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // A pop is only possible when an entry is presented; ready is ignored when empty.
    assign w_pop   = !w_empty && io_out_ready;
    // A full queue still accepts a beat when the head leaves in the same cycle.
    assign w_push  = io_in_en && (!w_full || w_pop);

    // Write the incoming beat into the slot at the write pointer.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= {io_in_result_h, io_in_result_l};
            r_usr_mem[r_wr_ptr]  <= io_in_usr;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: a beat arrived while full and nothing left to make room.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (io_in_en && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign io_out_valid = !w_empty;
    assign io_out_data  = w_empty ? 64'd0 : r_data_mem[r_rd_ptr];
    assign io_out_usr   = w_empty ? '0 : r_usr_mem[r_rd_ptr];
    // Raised SKID entries before full so beats already launched still have room.
    assign io_stop      = (r_count >= STOP_CNT);
    assign io_count     = r_count;
    assign io_overflow  = r_overflow;

endmodule

// File: tb/tb_mult32_result_queue.sv
// Bench for mult32_result_queue: directed scenarios plus a randomized product
// stream, checked by a queue-based reference model and a negedge monitor.
module tb_mult32_result_queue;

    localparam int DEPTH = 4;
    localparam int SKID  = 1;
    localparam int USR_W = 5;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = 64 + USR_W;

    logic               clock;
    logic               reset;
    logic [31:0]        io_in_result_l;
    logic [31:0]        io_in_result_h;
    logic [USR_W-1:0]   io_in_usr;
    logic               io_in_en;
    logic               io_stop;
    logic [63:0]        io_out_data;
    logic [USR_W-1:0]   io_out_usr;
    logic               io_out_valid;
    logic               io_out_ready;
    logic [CNT_W-1:0]   io_count;
    logic               io_overflow;

    mult32_result_queue #(.DEPTH(DEPTH), .SKID(SKID), .USR_W(USR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_result_l (io_in_result_l),
        .io_in_result_h (io_in_result_h),
        .io_in_usr      (io_in_usr),
        .io_in_en       (io_in_en),
        .io_stop        (io_stop),
        .io_out_data    (io_out_data),
        .io_out_usr     (io_out_usr),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_count       (io_count),
        .io_overflow    (io_overflow)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- counters ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // exp_q holds the beats the queue should contain, head first.
    logic [W-1:0] exp_q[$];
    logic         ovf_m;
    logic         pop_pending;

    // Accept rule: a beat is stored when the queue is not full, or when the
    // head leaves on the same edge; otherwise it is lost and overflow latches.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            ovf_m       = 1'b0;
            pop_pending = 1'b0;
        end else begin
            int occ;
            occ = exp_q.size() + (pop_pending ? 1 : 0);
            if (io_in_en) begin
                if (occ < DEPTH || pop_pending)
                    exp_q.push_back({io_in_result_h, io_in_result_l, io_in_usr});
                else
                    ovf_m = 1'b1;
            end
            pop_pending = 1'b0;
        end
    end

    // Monitor: compares status every cycle and pops the expected head whenever
    // the consumer takes a beat on the coming edge.
    always @(negedge clock) begin
        if (!reset) begin
            int sz;
            sz = exp_q.size();
            check("count",    W'(io_count),     W'(sz));
            check("valid",    W'(io_out_valid), W'(sz != 0));
            check("stop",     W'(io_stop),      W'(sz >= DEPTH - SKID));
            check("overflow", W'(io_overflow),  W'(ovf_m));
            if (sz == 0) begin
                check("empty_data", {io_out_data, io_out_usr}, '0);
            end else if (io_out_ready) begin
                logic [W-1:0] exp_beat;
                exp_beat = exp_q.pop_front();
                check("head_beat", {io_out_data, io_out_usr}, exp_beat);
                pop_pending = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    // Inputs change 1 time unit after each rising edge.
    task automatic step(input logic en, input logic [63:0] prod,
                        input logic [USR_W-1:0] usr, input logic rdy);
        io_in_en       = en;
        io_in_result_h = prod[63:32];
        io_in_result_l = prod[31:0];
        io_in_usr      = usr;
        io_out_ready   = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        io_in_en     = 1'b0;
        io_out_ready = 1'b0;
        reset        = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic        stop_prev;
    logic        saw_stop_hi;
    logic        saw_stop_lo_after;
    logic [31:0] a;
    logic [31:0] b;

    initial begin
        io_in_en       = 1'b0;
        io_in_result_h = '0;
        io_in_result_l = '0;
        io_in_usr      = '0;
        io_out_ready   = 1'b0;

        // 1. reset held 5 cycles
        do_reset(5);
        check("rst_valid",    W'(io_out_valid), '0);
        check("rst_stop",     W'(io_stop),      '0);
        check("rst_count",    W'(io_count),     '0);
        check("rst_overflow", W'(io_overflow),  '0);

        // reset in the middle of a fill
        for (int i = 1; i <= 3; i++) step(1'b1, 64'(i) * 64'h1111, USR_W'(i), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        check("midfill_count", W'(io_count), W'(3));
        reset = 1'b1;
        #1;
        check("async_rst_valid", W'(io_out_valid), '0);
        check("async_rst_count", W'(io_count),     '0);
        check("async_rst_stop",  W'(io_stop),      '0);
        check("async_rst_data",  {io_out_data, io_out_usr}, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // 2. single beat, consumer ready
        step(1'b1, 64'h00000001_00000002, 5'd5, 1'b1);
        check("single_valid", W'(io_out_valid), W'(1));
        check("single_data",  W'(io_out_data),  W'(64'h00000001_00000002));
        check("single_usr",   W'(io_out_usr),   W'(5));
        step(1'b0, '0, '0, 1'b1);
        check("single_drained", W'(io_count), '0);

        // 3. fill with ready low, overflow on the fifth beat, drain in order
        for (int i = 1; i <= 3; i++) step(1'b1, {32'(i), 32'hA5A5_0000 + 32'(i)}, USR_W'(i), 1'b0);
        check("fill3_stop",  W'(io_stop),  W'(1));
        check("fill3_count", W'(io_count), W'(3));
        step(1'b1, {32'd4, 32'hA5A5_0004}, 5'd4, 1'b0);
        check("fill4_count", W'(io_count), W'(4));
        check("fill4_ovf",   W'(io_overflow), '0);
        step(1'b1, {32'd5, 32'hA5A5_0005}, 5'd5, 1'b0);
        check("drop_count", W'(io_count),    W'(4));
        check("drop_ovf",   W'(io_overflow), W'(1));
        repeat (6) step(1'b0, '0, '0, 1'b1);
        check("drain3_count", W'(io_count), '0);
        check("ovf_sticky",   W'(io_overflow), W'(1));

        // 4. full queue with push and pop together
        do_reset(2);
        for (int i = 11; i <= 14; i++) step(1'b1, {32'hBEEF_0000, 32'(i)}, USR_W'(i), 1'b0);
        step(1'b1, {32'hCAFE_0000, 32'd15}, 5'd15, 1'b1);
        check("fullpp_count", W'(io_count),    W'(4));
        check("fullpp_ovf",   W'(io_overflow), '0);
        repeat (6) step(1'b0, '0, '0, 1'b1);
        check("fullpp_drained", W'(io_count), '0);

        // 5. random product stream, one beat every 7 cycles, random ready
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            step(1'b1, 64'(a) * 64'(b), USR_W'(i), 1'($urandom_range(0, 1)));
            repeat (6) step(1'b0, '0, '0, 1'($urandom_range(0, 1)));
        end
        repeat (8) step(1'b0, '0, '0, 1'b1);
        check("stream_drained", W'(io_count), '0);

        // 6. back-pressure loop: source honours io_stop one cycle late
        do_reset(2);
        stop_prev         = 1'b0;
        saw_stop_hi       = 1'b0;
        saw_stop_lo_after = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic en;
            en = !stop_prev;
            stop_prev = io_stop;
            if (io_stop) saw_stop_hi = 1'b1;
            else if (saw_stop_hi) saw_stop_lo_after = 1'b1;
            a = $urandom;
            b = $urandom;
            step(en, 64'(a) * 64'(b), USR_W'(i), ($urandom_range(0, 3) == 0));
        end
        repeat (8) step(1'b0, '0, '0, 1'b1);
        check("bp_no_overflow", W'(io_overflow), '0);
        check("bp_stop_toggled", W'(saw_stop_hi && saw_stop_lo_after), W'(1));
        check("bp_drained", W'(io_count), '0);
        check("model_empty", W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
